// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux with a registered output stage.
// Define STREAM_MUX_RR_EN to compile in the round-robin arbiter (rr_mode).
module stream_mux_n #(
  parameter  int N       = 4,
  parameter  int W       = 8,
  parameter  int SLICE_W = 2,
  localparam int SW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [SW-1:0]    sel,
  input  logic             rr_mode,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NS = W / SLICE_W;

  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt;
  logic          w_can_load;
  logic          w_acc;
  logic [W-1:0]  w_mux;

  logic [W-1:0]  r_data;
  logic [SW-1:0] r_chan;
  logic          r_valid;

`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] w_idx;
`else
  logic          w_unused_rr;
  assign w_unused_rr = rr_mode;
`endif

  always_comb begin
    w_gnt     = sel;
    w_gnt_vld = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (sel == SW'(c)) w_gnt_vld = 1'b1;
    end
`ifdef STREAM_MUX_RR_EN
    w_idx = '0;
    // Cyclic search starting just after the last granted channel
    if (rr_mode) begin
      w_gnt     = '0;
      w_gnt_vld = 1'b0;
      for (int i = 1; i <= N; i++) begin
        w_idx = SW'((int'(r_ptr) + i) % N);
        if (!w_gnt_vld && in_valid[w_idx]) begin
          w_gnt     = w_idx;
          w_gnt_vld = 1'b1;
        end
      end
    end
`endif
  end

  assign w_can_load = !r_valid || out_ready;

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < N; c++) begin
      in_ready[c] = !rst && w_gnt_vld && w_can_load
                    && (w_gnt == SW'(c));
    end
  end

  assign w_acc = |(in_ready & in_valid);

  // AND-OR style slice muxes keep X on unselected channels out of the path
  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [SLICE_W-1:0] w_slc;
    always_comb begin
      w_slc = '0;
      for (int c = 0; c < N; c++) begin
        if (w_gnt == SW'(c))
          w_slc = in_data[c*W + s*SLICE_W +: SLICE_W];
      end
    end
    assign w_mux[s*SLICE_W +: SLICE_W] = w_slc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_mux;
      r_chan  <= w_gnt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_RR_EN
  always_ff @(posedge clk) begin
    if (rst)        r_ptr <= SW'(N - 1);
    else if (w_acc) r_ptr <= w_gnt;
  end
`endif

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: vector table, hand sequences, scoreboard.
// Round-robin rows run only when STREAM_MUX_RR_EN is defined.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din;
  logic [3:0]  vld = '0;
  logic [3:0]  rdy;
  logic [1:0]  sel = '0;
  logic        rr = 1'b0;
  logic [7:0]  od;
  logic [1:0]  oc;
  logic        ov;
  logic        ordy = 1'b1;

  logic [23:0] din3;
  logic [2:0]  vld3 = '0;
  logic [2:0]  rdy3;
  logic [1:0]  sel3 = '0;
  logic [7:0]  od3;
  logic [1:0]  oc3;
  logic        ov3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_mux_n #(.N(4), .W(8), .SLICE_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld),
    .in_ready(rdy), .sel(sel), .rr_mode(rr), .out_data(od),
    .out_chan(oc), .out_valid(ov), .out_ready(ordy)
  );

  stream_mux_n #(.N(3), .W(8), .SLICE_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(din3), .in_valid(vld3),
    .in_ready(rdy3), .sel(sel3), .rr_mode(1'b0), .out_data(od3),
    .out_chan(oc3), .out_valid(ov3), .out_ready(1'b1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard with a small behavioural model of the grant logic
  logic [9:0] q[$];
  logic       m_valid = 1'b0;
  int         m_ptr = 3;
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    logic rre;
    logic acc;
    logic [9:0] e;
    if (mon_en) begin
`ifdef STREAM_MUX_RR_EN
      rre = rr;
`else
      rre = 1'b0;
`endif
      g = -1;
      if (rre) begin
        for (int k = 1; k <= 4; k++)
          if (g < 0 && vld[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end else begin
        g = int'(sel);
      end
      er = '0;
      if (!rst && g >= 0 && (!m_valid || ordy)) er[g] = 1'b1;
      chk("mon_in_ready", rdy, er);
      chk("mon_out_valid", ov, m_valid);
      if (!rst && m_valid && ordy) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got word %h expected none", od);
        end else begin
          e = q.pop_front();
          chk("sb_data", od, e[7:0]);
          chk("sb_chan", oc, e[9:8]);
        end
      end
      acc = (g >= 0) && er[g] && vld[g];
      if (rst) begin
        m_valid = 1'b0;
        m_ptr   = 3;
        q.delete();
      end else if (acc) begin
        q.push_back({2'(g), din[g*8 +: 8]});
        m_valid = 1'b1;
        m_ptr   = g;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       rr;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic       chk_d;
    logic [7:0] e_od;
    logic [1:0] e_oc;
  } vec_t;

  function automatic vec_t mk(logic r, logic m, logic [1:0] s,
                              logic [3:0] v, logic o, logic [3:0] er,
                              logic ev, logic cd, logic [7:0] ed,
                              logic [1:0] ec);
    vec_t t;
    t.rst = r; t.rr = m; t.sel = s; t.vld = v; t.ordy = o;
    t.e_rdy = er; t.e_ov = ev; t.chk_d = cd; t.e_od = ed; t.e_oc = ec;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t t, input string nm);
    rst = t.rst; rr = t.rr; sel = t.sel; vld = t.vld; ordy = t.ordy;
    #1;
    chk({nm, "_in_ready"}, rdy, t.e_rdy);
    chk({nm, "_out_valid"}, ov, t.e_ov);
    if (t.chk_d) begin
      chk({nm, "_out_data"}, od, t.e_od);
      chk({nm, "_out_chan"}, oc, t.e_oc);
    end
    tick();
  endtask

  vec_t tv[$];

  initial begin
    din  = {8'hd3, 8'hc2, 8'hb1, 8'ha0};
    din3 = {8'hc2, 8'hb1, 8'ha0};
    tick();
    mon_en = 1'b1;
    tick();

    // Fixed select, then backpressure on channel 2
    tv.push_back(mk(0,0,0,4'hf,1,4'b0001,0,1,8'h00,0));
    tv.push_back(mk(0,0,1,4'hf,1,4'b0010,1,1,8'ha0,0));
    tv.push_back(mk(0,0,2,4'hf,1,4'b0100,1,1,8'hb1,1));
    tv.push_back(mk(0,0,3,4'hf,1,4'b1000,1,1,8'hc2,2));
    tv.push_back(mk(0,0,2,4'hf,1,4'b0100,1,1,8'hd3,3));
    tv.push_back(mk(0,0,2,4'hf,0,4'b0000,1,1,8'hc2,2));
    tv.push_back(mk(0,0,2,4'hf,0,4'b0000,1,1,8'hc2,2));
    tv.push_back(mk(0,0,2,4'hf,0,4'b0000,1,1,8'hc2,2));
    tv.push_back(mk(0,0,2,4'hf,1,4'b0100,1,1,8'hc2,2));
    tv.push_back(mk(0,0,2,4'h0,1,4'b0100,1,1,8'hc2,2));
    tv.push_back(mk(0,0,2,4'h0,1,4'b0100,0,0,8'h00,0));
    for (int i = 0; i < tv.size(); i++)
      run(tv[i], $sformatf("fix%0d", i));

    // Unknown data on an unselected channel
    din = {8'hd3, 8'hc2, 8'hxx, 8'ha0};
    run(mk(0,0,0,4'hf,1,4'b0001,0,0,8'h00,0), "x0");
    run(mk(0,0,2,4'hf,1,4'b0100,1,1,8'ha0,0), "x1");
    vld = '0;
    #1;
    chk("x_out_data", od, 8'hc2);
    chk("x_no_unknown", 32'($isunknown(od)), 0);
    tick();
    din = {8'hd3, 8'hc2, 8'hb1, 8'ha0};

    // N=3: out-of-range select grants nothing
    sel3 = 2'd3;
    vld3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("n3_oor_ready%0d", i), rdy3, 3'b000);
      chk($sformatf("n3_oor_valid%0d", i), ov3, 1'b0);
      tick();
    end
    sel3 = 2'd2;
    #1;
    chk("n3_sel2_ready", rdy3, 3'b100);
    tick();
    chk("n3_sel2_valid", ov3, 1'b1);
    chk("n3_sel2_data", od3, 8'hc2);
    chk("n3_sel2_chan", oc3, 2'd2);
    vld3 = '0;

    tv.delete();
    tv.push_back(mk(1,1,2,4'b1011,1,4'b0000,0,0,8'h00,0));
`ifdef STREAM_MUX_RR_EN
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0001,0,1,8'h00,0));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0010,1,1,8'ha0,0));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b1000,1,1,8'hb1,1));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0001,1,1,8'hd3,3));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0010,1,1,8'ha0,0));
    tv.push_back(mk(0,1,2,4'b1011,0,4'b0000,1,1,8'hb1,1));
    tv.push_back(mk(0,1,2,4'b1011,0,4'b0000,1,1,8'hb1,1));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b1000,1,1,8'hb1,1));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0001,1,1,8'hd3,3));
    tv.push_back(mk(1,1,2,4'b1011,1,4'b0000,1,1,8'ha0,0));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0001,0,1,8'h00,0));
    tv.push_back(mk(0,1,2,4'b1011,1,4'b0010,1,1,8'ha0,0));
`else
    tv.push_back(mk(0,1,1,4'hf,1,4'b0010,0,1,8'h00,0));
    tv.push_back(mk(0,1,1,4'hf,1,4'b0010,1,1,8'hb1,1));
    tv.push_back(mk(0,1,1,4'h0,1,4'b0010,1,1,8'hb1,1));
`endif
    for (int i = 0; i < tv.size(); i++)
      run(tv[i], $sformatf("rr%0d", i));

    rr   = 1'b0;
    vld  = '0;
    ordy = 1'b1;
    tick();
    tick();
    chk("sb_drain", q.size(), 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel, W-bit stream multiplexer with a valid/ready handshake on every channel and a registered output stage. The datapath is built from SLICE_W-wide slice multiplexers that share one select. Channel choice comes either from an explicit select port or from an optional round-robin arbiter. The block merges several producer streams into one consumer stream.

## Interface
- N, default 4: number of input channels, N ≥ 2.
- W, default 8: data width per channel; must be a multiple of SLICE_W.
- SLICE_W, default 2: width of one slice multiplexer; W/SLICE_W slices share the select.
- SW, default $clog2(N): select width (localparam).
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready, combinational.
- sel  input  SW  explicit channel select, used when rr_mode = 0.
- rr_mode  input  1  1 selects round-robin arbitration; ignored (treated as 0) when the macro is absent.
- out_data  output  W  registered output data.
- out_chan  output  SW  registered index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

## Operation
- Grant g:
  - Fixed mode: g = sel. If sel ≥ N, no channel is granted and all in_ready are 0.
  - Round-robin mode: g is the first channel with in_valid set, searching cyclically from ptr+1. If no channel is valid, there is no grant.
- Ready: in_ready[c] = (c == g) && (!out_valid || out_ready). Every other bit is 0.
- Transfer in: in_valid[g] && in_ready[g] loads out_data ← slice-mux of channel g and out_chan ← g, and sets out_valid ← 1.
- Transfer out: out_valid && out_ready. If no new transfer in occurs in the same cycle, out_valid ← 0.
- Simultaneous in and out transfer in one cycle: the register reloads, out_valid stays 1, and throughput is one word per cycle.
- Stall: while out_valid && !out_ready, out_data and out_chan hold and all in_ready are 0.
- Round-robin pointer ptr updates to g only on a transfer in. A stalled or idle cycle does not advance it.
- Sel and rr_mode changes take effect immediately in the combinational grant. The registered word is unaffected.
- Reset values: out_valid 0, out_data 0, out_chan 0, ptr N−1 (channel 0 has first priority).

## Timing
- Input-to-output latency is 1 cycle: a word accepted at edge k is on out_data, with out_valid = 1, after edge k.
- in_ready depends combinationally on sel, rr_mode, in_valid, out_valid and out_ready. No other combinational paths exist.
- Reset mid-operation: the held word is dropped, out_valid = 0 on the next cycle, and ptr returns to N−1.
- in_ready is 0 while rst = 1.
- Producers must hold in_data and in_valid stable until accepted. Fixed mode does not require sel to be stable.

## Configuration
- STREAM_MUX_RR_EN defined:
  - The round-robin arbiter and ptr register are compiled in.
  - rr_mode selects between fixed and round-robin mode.
- STREAM_MUX_RR_EN undefined:
  - No arbiter and no ptr.
  - rr_mode is ignored and the block is always in fixed mode.

## Test plan
- Use N=4, W=8, SLICE_W=2.
- Fixed select:
  - Stimulus: rr_mode=0, in_data = {8'hd3, 8'hc2, 8'hb1, 8'ha0}, all valid, out_ready=1, sel stepping 0..3.
  - Required: out_data sequence a0, b1, c2, d3, one cycle after each selection; out_chan 0..3; in_ready one-hot matching sel.
- Backpressure:
  - Stimulus: sel=2, out_ready=0 for 3 cycles after the first accept.
  - Required: out_data holds c2, in_ready=0000 during the stall, no word is lost or duplicated after out_ready returns to 1.
- Out-of-range and X:
  - Stimulus: N=3 build, sel=3.
  - Required: in_ready=000 and out_valid stays 0.
  - Stimulus: channel data 8'hxx with sel pointing elsewhere.
  - Required: out_data carries no X.
- Round robin (macro defined):
  - Stimulus: rr_mode=1, channels 0, 1 and 3 continuously valid, out_ready=1.
  - Required: grant order 0, 1, 3, 0, 1, 3, …; ptr unchanged during a 2-cycle out_ready=0 stall.
- Reset mid-stream:
  - Stimulus: rst=1 for one cycle while out_valid=1 in round-robin mode.
  - Required: out_valid=0, out_data=0, out_chan=0 next cycle; the next grant goes to channel 0 if it is valid.
- Macro undefined:
  - Stimulus: rr_mode=1, sel=1.
  - Required: behaviour identical to fixed mode with only channel 1 granted.
